// File: rtl/generic_fifo_ext_pkg.sv
// Shared helpers for generic_fifo_ext: width calculation and modulo-DEPTH pointer increment.
package generic_fifo_ext_pkg;

    // Bits needed to index `value` items; never less than 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return (r < 1) ? 1 : r;
    endfunction

    // Works for any depth, not only powers of two.
    function automatic int wrap_inc(input int ptr, input int depth);
        return (ptr >= depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/fifo_ptr_wrap.sv
// FIFO pointer with enable that wraps DEPTH-1 -> 0; exposes current and next value.
module fifo_ptr_wrap
    import generic_fifo_ext_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int PTR_SIZE = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    output logic [PTR_SIZE-1:0] ptr,
    output logic [PTR_SIZE-1:0] ptr_next
);

    always_comb ptr_next = en ? PTR_SIZE'(wrap_inc(int'(ptr), DEPTH)) : ptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ptr <= '0;
        else       ptr <= ptr_next;
    end

endmodule

// File: rtl/generic_fifo_ext.sv
// Single-clock FIFO using all DEPTH entries (occupancy counter), optional FWFT read,
// almost-full/almost-empty thresholds and overflow/underflow pulses.
module generic_fifo_ext
    import generic_fifo_ext_pkg::*;
#(
    parameter int DATA_SIZE       = 32,
    parameter int DEPTH           = 8,
    parameter int FWFT            = 0,
    parameter int ALMOST_FULL_TH  = DEPTH - 1,
    parameter int ALMOST_EMPTY_TH = 1,
    localparam int PTR_SIZE       = clog2(DEPTH),
    localparam int CNT_SIZE       = clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 write,
    input  logic [DATA_SIZE-1:0] data_in,
    input  logic                 read,
    output logic [DATA_SIZE-1:0] data_out,
    output logic                 full,
    output logic                 almost_full,
    output logic                 empty,
    output logic                 almost_empty,
    output logic                 overflow,
    output logic                 underflow,
    output logic [CNT_SIZE-1:0]  size
);

    localparam logic [CNT_SIZE-1:0] DEPTH_C = CNT_SIZE'(DEPTH);
    localparam logic [CNT_SIZE-1:0] AF_C    = CNT_SIZE'(ALMOST_FULL_TH);
    localparam logic [CNT_SIZE-1:0] AE_C    = CNT_SIZE'(ALMOST_EMPTY_TH);

    if (DATA_SIZE < 1 || DEPTH < 2 ||
        ALMOST_FULL_TH < 0 || ALMOST_FULL_TH > DEPTH ||
        ALMOST_EMPTY_TH < 0 || ALMOST_EMPTY_TH > DEPTH) begin : g_bad_cfg
        $error("generic_fifo_ext: DATA_SIZE/DEPTH/threshold parameters out of range");
    end

    logic [DATA_SIZE-1:0] mem [DEPTH];
    logic [PTR_SIZE-1:0]  wr_ptr, wr_next, rd_ptr, rd_next;
    logic                 wr_en, rd_en;
    logic [CNT_SIZE-1:0]  size_next;

    assign wr_en = write && !full;
    assign rd_en = read && !empty;

    always_comb size_next = size + CNT_SIZE'(wr_en) - CNT_SIZE'(rd_en);

    fifo_ptr_wrap #(.DEPTH(DEPTH), .PTR_SIZE(PTR_SIZE)) u_wr_ptr (
        .clk(clk), .reset(reset), .en(wr_en), .ptr(wr_ptr), .ptr_next(wr_next)
    );

    fifo_ptr_wrap #(.DEPTH(DEPTH), .PTR_SIZE(PTR_SIZE)) u_rd_ptr (
        .clk(clk), .reset(reset), .en(rd_en), .ptr(rd_ptr), .ptr_next(rd_next)
    );

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= data_in;
    end

    // Flags come from size_next so they line up with size in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            size         <= '0;
            full         <= 1'b0;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            size         <= size_next;
            full         <= (size_next == DEPTH_C);
            almost_full  <= (size_next >= AF_C);
            almost_empty <= (size_next <= AE_C);
            overflow     <= write && full;
            underflow    <= read && empty;
        end
    end

    if (FWFT != 0) begin : g_fwft
        logic empty_q;
        // The head fetch reads memory before this edge's write lands, so a word
        // only counts as presented once it was stored on an earlier edge.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                data_out <= '0;
                empty_q  <= 1'b1;
            end else begin
                data_out <= mem[rd_next];
                empty_q  <= ((size - CNT_SIZE'(rd_en)) == '0);
            end
        end
        assign empty = empty_q;
    end else begin : g_std
        always_ff @(posedge clk or posedge reset) begin
            if (reset)      data_out <= '0;
            else if (rd_en) data_out <= mem[rd_ptr];
        end
        assign empty = (size == '0);
    end

endmodule

// File: tb/tb_generic_fifo_ext.sv
// Scoreboard bench for generic_fifo_ext: three configurations (D8 std, D5 std, D8 FWFT).
module tb_generic_fifo_ext;

    localparam int N = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr [N];
    logic        rd [N];
    logic [31:0] din [N];
    logic [31:0] dout [N];
    logic        fl [N], afl [N], em [N], aem [N], ov [N], un [N];
    logic [3:0]  sz0, sz2;
    logic [2:0]  sz1;
    logic [3:0]  sz [N];

    always #5 clk = ~clk;

    always_comb begin
        sz[0] = sz0;
        sz[1] = {1'b0, sz1};
        sz[2] = sz2;
    end

    generic_fifo_ext #(.DATA_SIZE(32), .DEPTH(8), .FWFT(0), .ALMOST_FULL_TH(6), .ALMOST_EMPTY_TH(2)) u_a (
        .clk(clk), .reset(reset), .write(wr[0]), .data_in(din[0]), .read(rd[0]), .data_out(dout[0]),
        .full(fl[0]), .almost_full(afl[0]), .empty(em[0]), .almost_empty(aem[0]),
        .overflow(ov[0]), .underflow(un[0]), .size(sz0));

    generic_fifo_ext #(.DATA_SIZE(32), .DEPTH(5), .FWFT(0)) u_b (
        .clk(clk), .reset(reset), .write(wr[1]), .data_in(din[1]), .read(rd[1]), .data_out(dout[1]),
        .full(fl[1]), .almost_full(afl[1]), .empty(em[1]), .almost_empty(aem[1]),
        .overflow(ov[1]), .underflow(un[1]), .size(sz1));

    generic_fifo_ext #(.DATA_SIZE(32), .DEPTH(8), .FWFT(1)) u_c (
        .clk(clk), .reset(reset), .write(wr[2]), .data_in(din[2]), .read(rd[2]), .data_out(dout[2]),
        .full(fl[2]), .almost_full(afl[2]), .empty(em[2]), .almost_empty(aem[2]),
        .overflow(ov[2]), .underflow(un[2]), .size(sz2));

    int dep  [N] = '{8, 5, 8};
    int fw   [N] = '{0, 0, 1};
    int afth [N] = '{6, 4, 7};
    int aeth [N] = '{2, 1, 1};

    // Reference: contents of the active instance plus the edge each word was stored on.
    logic [31:0] qd [$];
    int          qe [$];
    bit          m_empty;
    logic [31:0] m_dout [N];
    int          edge_n;
    int          checks;
    int          errors;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int i, input bit w, input bit r, input logic [31:0] d);
        bit full_pre, empty_pre, wa, ra;
        @(negedge clk);
        for (int j = 0; j < N; j++) begin
            wr[j] = 1'b0;
            rd[j] = 1'b0;
        end
        wr[i] = w; rd[i] = r; din[i] = d;
        full_pre  = (qd.size() == dep[i]);
        empty_pre = m_empty;
        wa = w && !full_pre;
        ra = r && !empty_pre;
        @(posedge clk);
        edge_n++;
        if (ra) begin
            m_dout[i] = qd.pop_front();
            void'(qe.pop_front());
        end
        if (wa) begin
            qd.push_back(d);
            qe.push_back(edge_n);
        end
        if (fw[i] != 0) m_empty = (qd.size() == 0) || (qe[0] == edge_n);
        else            m_empty = (qd.size() == 0);
        #1;
        chk("size",         32'(sz[i]),  32'(qd.size()));
        chk("full",         32'(fl[i]),  32'(qd.size() == dep[i]));
        chk("empty",        32'(em[i]),  32'(m_empty));
        chk("almost_full",  32'(afl[i]), 32'(qd.size() >= afth[i]));
        chk("almost_empty", 32'(aem[i]), 32'(qd.size() <= aeth[i]));
        chk("overflow",     32'(ov[i]),  32'(w && full_pre));
        chk("underflow",    32'(un[i]),  32'(r && empty_pre));
        if (fw[i] == 0)    chk("data_out", dout[i], m_dout[i]);
        else if (!m_empty) chk("fwft_head", dout[i], qd[0]);
    endtask

    task automatic drain(input int i);
        for (int k = 0; k < 2 * dep[i] + 4 && qd.size() > 0; k++) cyc(i, 1'b0, 1'b1, 32'h0);
    endtask

    task automatic scenario(input int i);
        for (int k = 0; k < dep[i]; k++) cyc(i, 1'b1, 1'b0, 32'h10 + 32'(k));
        cyc(i, 1'b1, 1'b0, 32'h99);               // rejected at full
        cyc(i, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < dep[i]; k++) cyc(i, 1'b0, 1'b1, 32'h0);
        cyc(i, 1'b0, 1'b1, 32'h0);               // rejected at empty
        for (int k = 0; k < 3; k++) cyc(i, 1'b1, 1'b0, 32'h20 + 32'(k));
        cyc(i, 1'b0, 1'b0, 32'h0);
        cyc(i, 1'b1, 1'b1, 32'h30);
        cyc(i, 1'b1, 1'b1, 32'h31);
        drain(i);
        for (int k = 0; k < dep[i]; k++) cyc(i, 1'b1, 1'b0, 32'h40 + 32'(k));
        cyc(i, 1'b1, 1'b1, 32'h5A);              // at full: read wins, write drops
        drain(i);
        cyc(i, 1'b0, 1'b0, 32'h0);
        cyc(i, 1'b1, 1'b1, 32'h66);              // at empty: write wins, read drops
        cyc(i, 1'b0, 1'b0, 32'h0);
        drain(i);
    endtask

    initial begin
        checks = 0; errors = 0; edge_n = 0; m_empty = 1'b1;
        for (int j = 0; j < N; j++) begin
            wr[j] = 1'b0; rd[j] = 1'b0; din[j] = '0; m_dout[j] = '0;
        end
        reset = 1'b1;
        #12;
        for (int j = 0; j < N; j++) begin
            chk("rst_size", 32'(sz[j]), 32'd0);
            chk("rst_empty", 32'(em[j]), 32'd1);
            chk("rst_full", 32'(fl[j]), 32'd0);
            chk("rst_af", 32'(afl[j]), 32'd0);
            chk("rst_ae", 32'(aem[j]), 32'd1);
            chk("rst_ov_un", 32'({ov[j], un[j]}), 32'd0);
            chk("rst_dout", dout[j], 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;

        scenario(0);

        for (int b = 0; b < 20; b++) begin
            int n;
            n = int'($urandom_range(1, 7));
            for (int k = 0; k < n; k++) begin
                if (b % 2 == 0) cyc(1, 1'b1, $urandom_range(0, 3) == 0, $urandom);
                else            cyc(1, $urandom_range(0, 3) == 0, 1'b1, $urandom);
            end
        end
        drain(1);

        cyc(2, 1'b1, 1'b0, 32'hAB);
        cyc(2, 1'b0, 1'b0, 32'h0);
        cyc(2, 1'b0, 1'b0, 32'h0);
        cyc(2, 1'b0, 1'b1, 32'h0);
        cyc(2, 1'b0, 1'b0, 32'h0);
        scenario(2);
        for (int k = 0; k < 60; k++) cyc(2, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom);
        drain(2);

        // Async reset in the middle of a cycle with 4 words stored.
        for (int k = 0; k < 4; k++) cyc(0, 1'b1, 1'b0, 32'h70 + 32'(k));
        cyc(0, 1'b0, 1'b1, 32'h0);
        cyc(0, 1'b1, 1'b0, 32'h74);
        cyc(0, 1'b0, 1'b0, 32'h0);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("arst_size", 32'(sz[0]), 32'd0);
        chk("arst_empty", 32'(em[0]), 32'd1);
        chk("arst_full", 32'(fl[0]), 32'd0);
        chk("arst_af_ae", 32'({afl[0], aem[0]}), 32'b01);
        chk("arst_dout", dout[0], 32'd0);
        qd.delete(); qe.delete(); m_empty = 1'b1;
        for (int j = 0; j < N; j++) m_dout[j] = '0;
        @(negedge clk);
        reset = 1'b0;
        cyc(0, 1'b1, 1'b0, 32'h55);
        cyc(0, 1'b0, 1'b1, 32'h0);
        chk("rt_55", dout[0], 32'h55);
        cyc(0, 1'b0, 1'b0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
